// File: rtl/bus_initiator_ctrl.sv
// Initiator-side sequencer: shifts one request onto the serial bus LSB-first,
// waits for the target acknowledge and collects the returned read byte.
module bus_initiator_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rw,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_timeout,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  bus_rw,
    output logic                  bus_data_out,
    output logic                  bus_data_out_valid,
    output logic                  bus_mode,
    input  logic                  bus_target_ready,
    input  logic                  bus_target_ack,
    input  logic                  bus_data_in,
    input  logic                  bus_data_in_valid
);

    localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int SHW  = $clog2(MAXW + 1);
    localparam int BCW  = $clog2(DATA_WIDTH + 1);
    localparam int WCW  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, ADDR, GAP_A, DATA, GAP_D, WAIT, RESP
    } state_t;

    state_t                state_q, state_d;
    logic                  rw_q, rw_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [SHW-1:0]        shift_cnt_q, shift_cnt_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [WCW-1:0]        wait_cnt_q, wait_cnt_d;
    logic                  ack_seen_q, ack_seen_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  ack_now;
    logic                  done;

    always_comb begin
        state_d       = state_q;
        rw_d          = rw_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        shift_cnt_d   = shift_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        ack_seen_d    = ack_seen_q;
        rsp_valid_d   = 1'b0;
        rsp_timeout_d = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        ack_now       = ack_seen_q || bus_target_ack;
        done          = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    rw_d        = req_rw;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    rdata_d     = '0;
                    shift_cnt_d = '0;
                    bit_cnt_d   = '0;
                    wait_cnt_d  = '0;
                    ack_seen_d  = 1'b0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                if (bus_target_ready) begin
                    shift_cnt_d = '0;
                    state_d     = ADDR;
                end else if (wait_cnt_q == WCW'(TIMEOUT - 1)) begin
                    state_d       = RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ADDR: begin
                addr_d = addr_q >> 1;
                if (shift_cnt_q == SHW'(ADDR_WIDTH - 1)) begin
                    shift_cnt_d = '0;
                    state_d     = GAP_A;
                end else begin
                    shift_cnt_d = shift_cnt_q + 1'b1;
                end
            end
            GAP_A: begin
                wait_cnt_d = '0;
                state_d    = rw_q ? DATA : WAIT;
            end
            DATA: begin
                wdata_d = wdata_q >> 1;
                if (shift_cnt_q == SHW'(DATA_WIDTH - 1)) begin
                    shift_cnt_d = '0;
                    state_d     = GAP_D;
                end else begin
                    shift_cnt_d = shift_cnt_q + 1'b1;
                end
            end
            GAP_D: begin
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                // Read bits land at the current count; anything past a full byte is dropped.
                if (!rw_q && bus_data_in_valid && bit_cnt_q != BCW'(DATA_WIDTH)) begin
                    for (int i = 0; i < DATA_WIDTH; i++) begin
                        if (bit_cnt_q == BCW'(i)) begin
                            rdata_d[i] = bus_data_in;
                        end
                    end
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                done = rw_q ? ack_now : (ack_now && bit_cnt_d == BCW'(DATA_WIDTH));
                if (done) begin
                    state_d       = RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = rw_q ? '0 : rdata_d;
                end else if (wait_cnt_q == WCW'(TIMEOUT - 1)) begin
                    state_d       = RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_q == ADDR || state_q == GAP_A || state_q == DATA ||
             state_q == GAP_D || state_q == WAIT) && bus_target_ack) begin
            ack_seen_d = 1'b1;
        end

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rw_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            shift_cnt_q   <= '0;
            bit_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            ack_seen_q    <= 1'b0;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            rw_q          <= rw_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            shift_cnt_q   <= shift_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            ack_seen_q    <= ack_seen_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_rdata_q   <= rsp_rdata_d;
        end
    end

    // Bus lines decode straight from the registered state so reset clears them at once.
    assign req_ready          = req_ready_q;
    assign rsp_valid          = rsp_valid_q;
    assign rsp_timeout        = rsp_timeout_q;
    assign rsp_rdata          = rsp_rdata_q;
    assign bus_rw             = (state_q != IDLE) && rw_q;
    assign bus_data_out_valid = (state_q == ADDR) || (state_q == DATA);
    assign bus_mode           = (state_q == DATA);
    assign bus_data_out       = ((state_q == ADDR) && addr_q[0]) ||
                                ((state_q == DATA) && wdata_q[0]);

endmodule

// File: tb/tb_bus_initiator_ctrl.sv
// Randomised bench for bus_initiator_ctrl: the bench plays a memory-backed target
// and a scoreboard checks every response against a transaction-level model.
module tb_bus_initiator_ctrl;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rw = 1'b0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_timeout;
    logic [7:0]  rsp_rdata;
    logic        bus_rw;
    logic        bus_data_out;
    logic        bus_data_out_valid;
    logic        bus_mode;
    logic        bus_target_ready = 1'b0;
    logic        bus_target_ack = 1'b0;
    logic        bus_data_in = 1'b0;
    logic        bus_data_in_valid = 1'b0;

    int cyc = 0;
    int n_compared = 0;
    int n_mismatched = 0;

    typedef struct {
        bit         timeout;
        logic [7:0] rdata;
    } rsp_t;

    rsp_t       exp_q[$];
    logic [7:0] ref_mem [logic [15:0]];
    logic [7:0] tgt_mem [logic [15:0]];

    bus_initiator_ctrl #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(8),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_rw(req_rw),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_timeout(rsp_timeout),
        .rsp_rdata(rsp_rdata),
        .bus_rw(bus_rw),
        .bus_data_out(bus_data_out),
        .bus_data_out_valid(bus_data_out_valid),
        .bus_mode(bus_mode),
        .bus_target_ready(bus_target_ready),
        .bus_target_ack(bus_target_ack),
        .bus_data_in(bus_data_in),
        .bus_data_in_valid(bus_data_in_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Initial contents of the target memory for addresses never written.
    function automatic logic [7:0] def_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5C;
    endfunction

    task automatic checkOutput(input string name, input longint act, input longint exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        rsp_t e;
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_rsp", longint'(rsp_valid), 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("rsp", longint'({rsp_timeout, rsp_rdata}), longint'({e.timeout, e.rdata}));
            end
        end
    end

    // Issues one request and plays the target for it; rdly = ready-low cycles after accept,
    // ack_off/bit schedule are relative to the first WAIT cycle W.
    task automatic applyStimulus(input bit rw, input logic [15:0] addr, input logic [7:0] wdata,
                                 input int rdly, input bit ack_en, input int ack_off,
                                 input bit ack_setup, input int nbits, input int bstart,
                                 input int maxgap);
        int          T, W, c, r, guard, na, nd, first_a, first_d, exp_r, a_cyc, done_cyc;
        bit          setup_to, ok, rw_bad;
        logic [15:0] obs_addr;
        logic [7:0]  obs_data, tgt_byte, exp_rdata;
        int          bcyc[16];
        rsp_t        e;

        guard = 0;
        while (req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (req_ready !== 1'b1) begin
            checkOutput("req_ready_wait", longint'(req_ready), 1);
            return;
        end
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_wdata = wdata;
        T         = cyc;

        setup_to = (rdly >= TO);
        W        = T + rdly + 19 + (rw ? 9 : 0);
        a_cyc    = W + ack_off;
        bcyc[0]  = W + bstart;
        for (int j = 1; j < 16; j++) begin
            bcyc[j] = bcyc[j-1] + 1 + int'($urandom_range(0, maxgap));
        end
        if (setup_to) begin
            ok    = 1'b0;
            exp_r = T + TO + 1;
        end else begin
            done_cyc = ack_en ? ((a_cyc > W) ? a_cyc : W) : -1;
            if (!rw) begin
                if (nbits < 8) done_cyc = -1;
                else if (done_cyc >= 0 && bcyc[7] > done_cyc) done_cyc = bcyc[7];
            end
            ok    = (done_cyc >= 0) && (done_cyc <= W + TO - 1);
            exp_r = ok ? done_cyc + 1 : W + TO;
        end
        exp_rdata = 8'h00;
        if (ok && !rw) exp_rdata = ref_mem.exists(addr) ? ref_mem[addr] : def_byte(addr);
        if (ok && rw) ref_mem[addr] = wdata;
        e.timeout = !ok;
        e.rdata   = exp_rdata;
        exp_q.push_back(e);

        na = 0; nd = 0; first_a = -1; first_d = -1; r = -1; rw_bad = 1'b0;
        obs_addr = '0; obs_data = '0; tgt_byte = '0;
        while (r < 0 && cyc < T + 200) begin
            @(negedge clk);
            c = cyc;
            req_valid = 1'b0;
            if (bus_rw !== rw) rw_bad = 1'b1;
            if (bus_data_out_valid === 1'b1) begin
                if (bus_mode === 1'b0) begin
                    if (na == 0) first_a = c;
                    if (na < 16) obs_addr[na] = bus_data_out;
                    na++;
                    if (na == 16) tgt_byte = tgt_mem.exists(obs_addr) ? tgt_mem[obs_addr] : def_byte(obs_addr);
                end else begin
                    if (nd == 0) first_d = c;
                    if (nd < 8) obs_data[nd] = bus_data_out;
                    nd++;
                end
            end
            if (rsp_valid === 1'b1) begin
                r = c;
            end else begin
                bus_target_ready  = (c >= T + rdly + 1);
                bus_target_ack    = (ack_en && c == a_cyc) || (ack_setup && c == T + 1);
                if (ack_en && c == a_cyc && rw && nd >= 8) tgt_mem[obs_addr] = obs_data;
                bus_data_in_valid = 1'b0;
                bus_data_in       = 1'b0;
                if (!rw && !setup_to) begin
                    if (c == W - 1) begin
                        bus_data_in_valid = 1'b1;
                        bus_data_in       = ~tgt_byte[0];
                    end
                    for (int j = 0; j < nbits; j++) begin
                        if (c == bcyc[j]) begin
                            bus_data_in_valid = 1'b1;
                            bus_data_in       = (j < 8) ? tgt_byte[j] : 1'($urandom_range(0, 1));
                        end
                    end
                end
            end
        end
        bus_target_ready  = 1'b0;
        bus_target_ack    = 1'b0;
        bus_data_in_valid = 1'b0;
        bus_data_in       = 1'b0;

        checkOutput("rsp_cycle", longint'(r - T), longint'(exp_r - T));
        checkOutput("addr_bit_count", longint'(na), setup_to ? 0 : 16);
        if (!setup_to) begin
            checkOutput("serial_addr", longint'(obs_addr), longint'(addr));
            checkOutput("first_addr_cycle", longint'(first_a - T), longint'(rdly + 2));
        end
        checkOutput("data_bit_count", longint'(nd), (rw && !setup_to) ? 8 : 0);
        if (rw && !setup_to) begin
            checkOutput("serial_data", longint'(obs_data), longint'(wdata));
            checkOutput("first_data_cycle", longint'(first_d - T), longint'(rdly + 19));
        end
        checkOutput("bus_rw_held", longint'(rw_bad), 0);
        @(negedge clk);
        checkOutput("idle_after_rsp", longint'({req_ready, bus_rw, bus_data_out_valid}), 4);
    endtask

    // Starts a write, pulls reset in the middle of address bit 7 and expects a silent abort.
    task automatic resetMidTransaction();
        int T, guard;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        req_valid        = 1'b1;
        req_rw           = 1'b1;
        req_addr         = 16'hC3A5;
        req_wdata        = 8'h3C;
        bus_target_ready = 1'b1;
        T                = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        while (cyc < T + 9) @(negedge clk);
        checkOutput("pre_reset_addr_bit7", longint'({bus_data_out_valid, bus_mode, bus_data_out}), 5);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_outputs", longint'({req_ready, rsp_valid, rsp_timeout, rsp_rdata, bus_rw,
                                               bus_data_out, bus_data_out_valid, bus_mode}), 0);
        bus_target_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("req_ready_after_reset", longint'(req_ready), 1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit          rw;
        logic [15:0] addr;
        logic [15:0] pool [4];
        int          sel, nb, rdly, aoff;

        pool[0] = 16'h4A32; pool[1] = 16'h1234; pool[2] = 16'h0F0F; pool[3] = 16'hBEEF;

        repeat (2) @(negedge clk);
        checkOutput("reset_state", longint'({req_ready, rsp_valid, rsp_timeout, rsp_rdata, bus_rw,
                                             bus_data_out, bus_data_out_valid, bus_mode}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("req_ready_after_reset", longint'(req_ready), 1);

        applyStimulus(1'b1, 16'h4A32, 8'h9E, 0, 1'b1, 2, 1'b0, 0, 0, 0);
        applyStimulus(1'b0, 16'h4A32, 8'h00, 0, 1'b1, 1, 1'b0, 8, 0, 0);
        applyStimulus(1'b1, 16'h1234, 8'hA5, 0, 1'b1, 0, 1'b0, 0, 0, 0);
        applyStimulus(1'b0, 16'h1234, 8'h00, 0, 1'b1, 4, 1'b0, 8, 0, 0);
        applyStimulus(1'b1, 16'h0F0F, 8'h5A, 10, 1'b1, 3, 1'b0, 0, 0, 0);
        applyStimulus(1'b0, 16'h0F0F, 8'h00, 30, 1'b1, 0, 1'b0, 8, 0, 0);
        applyStimulus(1'b0, 16'h0F0F, 8'h00, 0, 1'b0, 0, 1'b0, 0, 0, 0);
        applyStimulus(1'b1, 16'h2222, 8'h11, 0, 1'b0, 0, 1'b1, 0, 0, 0);
        applyStimulus(1'b0, 16'h0F0F, 8'h00, 2, 1'b1, 0, 1'b0, 7, 0, 1);
        applyStimulus(1'b0, 16'h0F0F, 8'h00, 0, 1'b1, -3, 1'b0, 10, 1, 1);
        resetMidTransaction();
        applyStimulus(1'b1, 16'hC3A5, 8'h77, 0, 1'b1, 0, 1'b0, 0, 0, 0);
        applyStimulus(1'b0, 16'hC3A5, 8'h00, 0, 1'b1, 0, 1'b0, 8, 0, 0);

        for (int k = 0; k < 30; k++) begin
            rw   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 4) == 0) ? 16'($urandom) : pool[$urandom_range(0, 3)];
            sel  = int'($urandom_range(0, 9));
            nb   = (sel == 0) ? 7 : (sel == 1) ? 10 : 8;
            rdly = ($urandom_range(0, 9) == 0) ? 25 : int'($urandom_range(0, 4));
            aoff = rw ? int'($urandom_range(0, 23)) - 1 : int'($urandom_range(0, 27)) - 5;
            applyStimulus(rw, addr, 8'($urandom), rdly, ($urandom_range(0, 9) != 0), aoff,
                          ($urandom_range(0, 7) == 0), nb, int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 2)));
        end

        repeat (2) @(negedge clk);
        checkOutput("pending_rsp", longint'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/bus_initiator_ctrl.md
Name: bus_initiator_ctrl

Overview:
Initiator-side sequencer for the serial bus. It accepts one parallel request (rw, 16-bit address, 8-bit write data) and serializes it onto the bus LSB-first, using bus_mode 0 for address and 1 for data. It then waits for the target acknowledge and, for reads, deserializes the 8 returned bits. It sits between a host/CPU-side request interface and the bus lines that feed target_port.

Parameters:
ADDR_WIDTH, 16, address bits shifted per transaction
DATA_WIDTH, 8, data bits shifted/captured per transaction
TIMEOUT, 255, max wait cycles in SETUP or WAIT before aborting; must be >=1

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  request strobe
req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready
req_rw  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  target address
req_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  one-cycle completion pulse, no backpressure
rsp_timeout  out  1  qualifies rsp_valid: transaction aborted
rsp_rdata  out  DATA_WIDTH  read data; valid with rsp_valid on a successful read
bus_rw  out  1  drives target_rw; held for the whole transaction
bus_data_out  out  1  serial bit to target_port
bus_data_out_valid  out  1  serial bit qualifier
bus_mode  out  1  0=address bit, 1=data bit
bus_target_ready  in  1  target can start a transaction
bus_target_ack  in  1  target acknowledge
bus_data_in  in  1  serial read bit from target_port
bus_data_in_valid  in  1  read bit qualifier

Behaviour:
- Reset (async): all outputs 0, state IDLE, counters and shift registers 0, ack_seen 0. Reset mid-transaction aborts with no rsp_valid.
- States: IDLE, SETUP, ADDR, GAP_A, DATA, GAP_D, WAIT, RESP.
- Accept cycle T: latch rw/addr/wdata, go to SETUP. bus_rw = latched rw from T+1 until the RESP cycle inclusive. bus_rw returns to 0 in IDLE.
- SETUP: serial outputs idle (valid 0, mode 0). Exit on the first cycle with bus_target_ready=1, with a minimum of 1 cycle. With ready high, ADDR occupies T+2..T+17.
- ADDR: ADDR_WIDTH cycles, bus_data_out = addr[i] (i=0 first), valid 1, mode 0.
- GAP_A: one cycle, valid 0, mode 0. Write goes to DATA. Read goes to WAIT.
- DATA (write only): DATA_WIDTH cycles, wdata[i] LSB-first, valid 1, mode 1. Then GAP_D, one idle cycle, then WAIT. With ready high, DATA is T+19..T+26 and GAP_D is T+27.
- ack_seen: sticky, set on any cycle with bus_target_ack=1 from ADDR entry onward, cleared on accept.
- Read capture (WAIT only, read transactions):
  - Each cycle with bus_data_in_valid=1 stores bus_data_in into rdata[bit_cnt] and increments bit_cnt.
  - Bits beyond DATA_WIDTH are ignored.
  - Valid bits outside WAIT are ignored.
- WAIT completion:
  - Write completes when ack_seen is set (including the same cycle as the ack).
  - Read completes when bit_cnt==DATA_WIDTH and ack_seen, in either order.
  - On completion go to RESP.
- RESP: rsp_valid=1 and rsp_timeout=0 for exactly one cycle. rsp_rdata = captured byte for reads, 0 for writes. Next state is IDLE, so req_ready rises the cycle after RESP.
- Timeout:
  - wait_cnt clears on entry to SETUP and to WAIT and increments every cycle in those states.
  - When wait_cnt reaches TIMEOUT without an exit condition, go to RESP with rsp_timeout=1 and rsp_rdata=0.
- rsp_valid, rsp_timeout and rsp_rdata are registered. rsp_rdata holds its value until the next RESP.
- ack pulses in IDLE/SETUP are ignored. req_valid outside IDLE is ignored.

Test Plan:
- Write 0x4A32/0x9E, target ready and acking:
  - bus_rw=1 from T+1.
  - ADDR T+2..T+17 bits 0,1,0,0,1,1,0,0,0,1,0,1,0,0,1,0 with mode 0.
  - Idle cycle at T+18.
  - DATA T+19..T+26 bits 0,1,1,1,1,0,0,1 with mode 1.
  - After ack: one rsp_valid pulse with rsp_timeout=0.
- Read 0x4A32 after the above write, with a real target behind target_port -> rsp_rdata=0x9E, rsp_timeout=0, bus_rw=0 throughout.
- Read where ack arrives 3 cycles before the last of 8 data bits (bits 0xA5) -> completion waits for bit 8; rsp_rdata=0xA5.
- bus_target_ready held low 10 cycles after accept -> serial valid stays 0; ADDR starts 1 cycle after ready rises. Ready never rising with TIMEOUT=20 -> rsp_valid with rsp_timeout=1, rsp_rdata=0.
- Read with no ack and no bits -> timeout response exactly TIMEOUT cycles after WAIT entry.
- rst_n asserted at address bit 7 -> all outputs 0 immediately, no rsp_valid. After release, a new write completes normally. Back-to-back requests are accepted one cycle after RESP.
